// File: rtl/parity_accum.sv
// parity_accum: per-frame column XOR, parity, saturating word count and overflow flag.
module parity_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    parameter bit          ODD   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_COLPAR,
    output logic             OUT_PARITY,
    output logic [CNT_W-1:0] OUT_COUNT,
    output logic             OUT_OVF
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state;
    logic [WIDTH-1:0] col_acc, col_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic ovf, sat, beat;
    assign IN_READY = !RST && state != HOLD;
    assign beat     = IN_VALID && IN_READY;
    assign sat      = &cnt;
    assign cnt_nxt  = sat ? cnt : cnt + 1'b1;
    assign col_nxt  = col_acc ^ IN_DATA;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            col_acc    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_COLPAR <= '0;
            OUT_PARITY <= 1'b0;
            OUT_COUNT  <= '0;
            OUT_OVF    <= 1'b0;
        end else if (beat && IN_LAST) begin
            state      <= HOLD;
            OUT_VALID  <= 1'b1;
            OUT_COLPAR <= col_nxt;
            OUT_PARITY <= ^col_nxt ^ ODD;
            OUT_COUNT  <= cnt_nxt;
            OUT_OVF    <= ovf | sat;
            col_acc    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
        end else if (beat) begin
            state   <= ACCUM;
            col_acc <= col_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf | sat;
        end else if (state == HOLD && OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_parity_accum.sv
// tb_parity_accum: directed table of per-cycle vectors plus saturation and odd-parity sequences.
module tb_parity_accum;
    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic rdy0, ov0, par0, ovf0, rdy1, ov1, par1, ovf1, rdy2, ov2, par2, ovf2;
    logic [7:0] col0, col1, col2, cnt0, cnt1;
    logic [1:0] cnt2;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic r, v, l;
        logic [7:0] d;
        logic o;
        logic e_rdy, e_ov;
        logic [7:0] e_col;
        logic e_par;
        logic [7:0] e_cnt;
        logic e_ovf;
    } vec_t;
    vec_t vec [25];
    always #5 clk = ~clk;
    parity_accum #(.WIDTH(8), .CNT_W(8), .ODD(1'b0)) d0 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_LAST(in_last),
        .IN_READY(rdy0), .OUT_VALID(ov0), .OUT_READY(out_ready), .OUT_COLPAR(col0),
        .OUT_PARITY(par0), .OUT_COUNT(cnt0), .OUT_OVF(ovf0));
    parity_accum #(.WIDTH(8), .CNT_W(8), .ODD(1'b1)) d1 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_LAST(in_last),
        .IN_READY(rdy1), .OUT_VALID(ov1), .OUT_READY(out_ready), .OUT_COLPAR(col1),
        .OUT_PARITY(par1), .OUT_COUNT(cnt1), .OUT_OVF(ovf1));
    parity_accum #(.WIDTH(8), .CNT_W(2), .ODD(1'b0)) d2 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_LAST(in_last),
        .IN_READY(rdy2), .OUT_VALID(ov2), .OUT_READY(out_ready), .OUT_COLPAR(col2),
        .OUT_PARITY(par2), .OUT_COUNT(cnt2), .OUT_OVF(ovf2));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input logic r, v, l, input logic [7:0] d, input logic o);
        @(negedge clk);
        rst = r; in_valid = v; in_last = l; in_data = d; out_ready = o;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        vec[0]  = '{1,0,0,8'h00,0, 0,0,8'h00,0,8'd0,0};
        vec[1]  = '{1,0,0,8'h00,0, 0,0,8'h00,0,8'd0,0};
        vec[2]  = '{0,0,0,8'h00,0, 1,0,8'h00,0,8'd0,0};
        vec[3]  = '{0,1,1,8'hA5,0, 0,1,8'hA5,0,8'd1,0};
        vec[4]  = '{0,0,0,8'h00,1, 1,0,8'hA5,0,8'd1,0};
        vec[5]  = '{0,1,0,8'h01,0, 1,0,8'hA5,0,8'd1,0};
        vec[6]  = '{0,1,0,8'h02,0, 1,0,8'hA5,0,8'd1,0};
        vec[7]  = '{0,1,1,8'h07,0, 0,1,8'h04,1,8'd3,0};
        vec[8]  = '{0,1,1,8'hFF,0, 0,1,8'h04,1,8'd3,0};
        vec[9]  = '{0,1,1,8'hFF,0, 0,1,8'h04,1,8'd3,0};
        vec[10] = '{0,1,0,8'hFF,0, 0,1,8'h04,1,8'd3,0};
        vec[11] = '{0,1,1,8'hFF,0, 0,1,8'h04,1,8'd3,0};
        vec[12] = '{0,1,1,8'hFF,0, 0,1,8'h04,1,8'd3,0};
        vec[13] = '{0,1,1,8'hFF,1, 1,0,8'h04,1,8'd3,0};
        vec[14] = '{0,1,1,8'h3C,0, 0,1,8'h3C,0,8'd1,0};
        vec[15] = '{0,0,0,8'h00,1, 1,0,8'h3C,0,8'd1,0};
        vec[16] = '{0,1,0,8'h11,0, 1,0,8'h3C,0,8'd1,0};
        vec[17] = '{0,1,0,8'h22,0, 1,0,8'h3C,0,8'd1,0};
        vec[18] = '{1,1,0,8'h00,0, 0,0,8'h00,0,8'd0,0};
        vec[19] = '{0,1,1,8'h0F,0, 0,1,8'h0F,0,8'd1,0};
        vec[20] = '{0,0,0,8'h00,1, 1,0,8'h0F,0,8'd1,0};
        vec[21] = '{0,1,1,8'h55,0, 0,1,8'h55,0,8'd1,0};
        vec[22] = '{1,1,1,8'h66,1, 0,0,8'h00,0,8'd0,0};
        vec[23] = '{0,0,0,8'h00,0, 1,0,8'h00,0,8'd0,0};
        vec[24] = '{0,0,1,8'hAA,0, 1,0,8'h00,0,8'd0,0};
        for (int i = 0; i < 25; i++) begin
            step(vec[i].r, vec[i].v, vec[i].l, vec[i].d, vec[i].o);
            chk($sformatf("v%0d in_ready", i), 64'(rdy0), 64'(vec[i].e_rdy));
            chk($sformatf("v%0d out_valid", i), 64'(ov0), 64'(vec[i].e_ov));
            chk($sformatf("v%0d colpar", i), 64'(col0), 64'(vec[i].e_col));
            chk($sformatf("v%0d parity", i), 64'(par0), 64'(vec[i].e_par));
            chk($sformatf("v%0d count", i), 64'(cnt0), 64'(vec[i].e_cnt));
            chk($sformatf("v%0d ovf", i), 64'(ovf0), 64'(vec[i].e_ovf));
        end
        step(1, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'hA5, 0);
        chk("odd valid", 64'(ov1), 64'd1);
        chk("odd colpar", 64'(col1), 64'hA5);
        chk("odd parity", 64'(par1), 64'd1);
        chk("odd count", 64'(cnt1), 64'd1);
        step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) step(0, 1, i == 2, 8'hFF, 0);
        chk("sat3 count", 64'(cnt2), 64'd3);
        chk("sat3 ovf", 64'(ovf2), 64'd0);
        chk("sat3 colpar", 64'(col2), 64'hFF);
        step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) step(0, 1, i == 4, 8'hFF, 0);
        chk("sat5 valid", 64'(ov2), 64'd1);
        chk("sat5 count", 64'(cnt2), 64'd3);
        chk("sat5 ovf", 64'(ovf2), 64'd1);
        chk("sat5 colpar", 64'(col2), 64'hFF);
        chk("sat5 parity", 64'(par2), 64'd0);
        chk("wide5 count", 64'(cnt0), 64'd5);
        chk("wide5 ovf", 64'(ovf0), 64'd0);
        step(0, 0, 0, 8'h00, 1);
        chk("sat5 release", 64'(rdy2), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parity_accum.md
PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input data word width in bits, 1..64.
REQ-002 SHALL have parameter CNT_W, default 8: word-count width in bits, 1..16.
REQ-003 SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_DATA  input  WIDTH  input data word.
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA/IN_LAST are valid.
REQ-008 SHALL have port IN_LAST  input  1  current beat is the final word of its frame.
REQ-009 SHALL have port IN_READY  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port OUT_VALID  output  1  frame result is available.
REQ-011 SHALL have port OUT_READY  input  1  consumer takes the result.
REQ-012 SHALL have port OUT_COLPAR  output  WIDTH  bitwise XOR of all words in the frame.
REQ-013 SHALL have port OUT_PARITY  output  1  XOR-reduction of OUT_COLPAR, XORed with ODD.
REQ-014 SHALL have port OUT_COUNT  output  CNT_W  number of words in the frame, saturating.
REQ-015 SHALL have port OUT_OVF  output  1  frame word count exceeded 2^CNT_W-1.

Function
REQ-016 SHALL implement a three-state FSM: IDLE (no beat accepted in current frame), ACCUM (at least one beat accepted, no last yet), HOLD (result pending).
REQ-017 SHALL define a beat as a cycle with IN_VALID=1 and IN_READY=1; all other cycles leave the accumulators unchanged.
REQ-018 SHALL drive IN_READY=1 in IDLE and ACCUM, and IN_READY=0 in HOLD and while RST=1.
REQ-019 SHALL, on a beat without IN_LAST, set col_acc <= col_acc ^ IN_DATA, increment cnt with saturation at 2^CNT_W-1, set ovf if cnt was already saturated, and move IDLE->ACCUM or stay in ACCUM.
REQ-020 SHALL, on a beat with IN_LAST, load OUT_COLPAR <= col_acc ^ IN_DATA, OUT_PARITY <= ^(col_acc ^ IN_DATA) ^ ODD, OUT_COUNT <= saturated cnt+1, and OUT_OVF <= ovf or (cnt saturated); clear col_acc, cnt and ovf; move to HOLD.
REQ-021 SHALL treat a single-beat frame (IN_LAST on the first beat in IDLE) identically to REQ-020, with col_acc=0 and cnt=0.
REQ-022 SHALL assert OUT_VALID exactly in HOLD, i.e. one cycle after the last beat, giving one-cycle latency.
REQ-023 SHALL hold OUT_COLPAR, OUT_PARITY, OUT_COUNT and OUT_OVF stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 SHALL, in HOLD with OUT_READY=1, transition to IDLE on that edge, so IN_READY=1 on the following cycle; one bubble cycle per frame is accepted.
REQ-025 SHALL ignore OUT_READY outside HOLD.
REQ-026 SHALL ignore IN_DATA and IN_LAST when IN_VALID=0.
REQ-027 SHALL never accept a beat while OUT_VALID=1.

Reset
REQ-028 SHALL, on any edge with RST=1, go to IDLE and clear col_acc, cnt, ovf, OUT_VALID, OUT_COLPAR, OUT_PARITY, OUT_COUNT and OUT_OVF to 0, regardless of state.
REQ-029 SHALL discard any partially accumulated frame or pending result when RST is asserted mid-operation; RST has priority over all beats and handshakes in the same cycle.

Verification
REQ-030 SHALL cover reset (WIDTH=8, ODD=0): hold RST 2 cycles -> all outputs 0 and IN_READY=0 during reset; IN_READY=1 on the first cycle after release.
REQ-031 SHALL cover a single-beat frame: beat 0xA5 with IN_LAST -> next cycle OUT_VALID=1, OUT_COLPAR=0xA5, OUT_PARITY=0, OUT_COUNT=1, OUT_OVF=0; repeat with ODD=1 -> OUT_PARITY=1.
REQ-032 SHALL cover a multi-beat frame: beats 0x01, 0x02, 0x07 (last) on consecutive cycles -> OUT_COLPAR=0x04, OUT_PARITY=1, OUT_COUNT=3.
REQ-033 SHALL cover backpressure: OUT_READY=0 for 5 cycles in HOLD with IN_VALID=1 -> outputs stable and IN_READY=0 throughout; OUT_READY=1 -> IDLE, and the next frame is accepted on the following cycle.
REQ-034 SHALL cover saturation: CNT_W=2, 5 beats of 0xFF with last on the fifth -> OUT_COUNT=3, OUT_OVF=1, OUT_COLPAR=0xFF, OUT_PARITY=0.
REQ-035 SHALL cover reset mid-frame: beats 0x11, 0x22 without last, then RST for 1 cycle, then 0x0F with last -> OUT_COLPAR=0x0F, OUT_COUNT=1, OUT_PARITY=0.
